spn_cu_iter: RTL and testbench

Parametrised, iterative SPN encrypt/decrypt core that applies one round per clock. A single shared round datapath replaces fully unrolled encrypt and decrypt pipelines. The core has valid/ready handshakes on input and output, a decryption path that exactly inverts encryption, and illegal-opcode reporting. It sits between the host command interface and the result buffer of the crypto unit.

---
 rtl/spn_cu_iter_pkg.sv | 12 +
 rtl/spn_cu_iter_if.sv | 25 ++
 rtl/spn_round_unit.sv | 29 ++
 rtl/spn_cu_iter.sv | 98 +++++++++
 tb/tb_spn_cu_iter.sv | 253 +++++++++++++++++++++++++
 5 files changed

// File: rtl/spn_cu_iter_pkg.sv
// spn_cu_iter_pkg: shared S-box tables, opcode and FSM state types for the iterative SPN core
package spn_cu_iter_pkg;
  typedef enum logic [1:0] {OP_NOP = 2'b00, OP_ENC = 2'b01, OP_DEC = 2'b10, OP_ILL = 2'b11} spn_op_e;
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} spn_state_e;
  localparam logic [3:0] SBOX [16] = '{4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
                                       4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2};
  localparam logic [3:0] SBOX_INV [16] = '{4'h5, 4'hE, 4'hF, 4'h8, 4'hC, 4'h1, 4'h2, 4'hD,
                                           4'hB, 4'h4, 4'h6, 4'h3, 4'h0, 4'h7, 4'h9, 4'hA};
  function automatic logic op_legal(input spn_op_e op);
    return op == OP_ENC || op == OP_DEC;
  endfunction
endpackage

// File: rtl/spn_cu_iter_if.sv
// spn_cu_iter_if: command/result handshake bundle between host, SPN core and result buffer
interface spn_cu_iter_if #(
  parameter int BLOCK_W = 16,
  parameter int KEY_W   = 32
);
  logic               in_valid;
  logic               in_ready;
  logic [1:0]         opcode;
  logic [BLOCK_W-1:0] data_in;
  logic [KEY_W-1:0]   symmetric_secret_key;
  logic               out_valid;
  logic               out_ready;
  logic [BLOCK_W-1:0] data_out;
  logic [1:0]         out_mode;
  logic               busy;
  logic               err_opcode;
  modport master (
    output in_valid, opcode, data_in, symmetric_secret_key, out_ready,
    input  in_ready, out_valid, data_out, out_mode, busy, err_opcode
  );
  modport slave (
    input  in_valid, opcode, data_in, symmetric_secret_key, out_ready,
    output in_ready, out_valid, data_out, out_mode, busy, err_opcode
  );
endinterface

// File: rtl/spn_round_unit.sv
// spn_round_unit: one combinational SPN round, encrypt P(S(x^k)) or decrypt S_INV(P_INV(x))^k
module spn_round_unit
  import spn_cu_iter_pkg::*;
#(
  parameter int BLOCK_W = 16
) (
  input  logic [BLOCK_W-1:0] x_i,
  input  logic [BLOCK_W-1:0] round_key_i,
  input  spn_op_e            mode_i,
  output logic [BLOCK_W-1:0] y_o
);
  localparam int N = BLOCK_W / 4;
  localparam int M = BLOCK_W - 1;
  logic [BLOCK_W-1:0] xk, s_enc, p_enc, p_dec, s_dec;
  genvar n, p;
  assign xk = x_i ^ round_key_i;
  for (n = 0; n < N; n++) begin : g_sbox
    assign s_enc[4*n +: 4] = SBOX[xk[4*n +: 4]];
    assign s_dec[4*n +: 4] = SBOX_INV[p_dec[4*n +: 4]];
  end
  // top bit is a fixed point; the rest scatter by a stride coprime with BLOCK_W-1
  assign p_enc[M] = s_enc[M];
  assign p_dec[M] = x_i[M];
  for (p = 0; p < M; p++) begin : g_perm
    assign p_enc[(p * N) % M] = s_enc[p];
    assign p_dec[p]           = x_i[(p * N) % M];
  end
  assign y_o = mode_i == OP_DEC ? s_dec ^ round_key_i : p_enc;
endmodule

// File: rtl/spn_cu_iter.sv
// spn_cu_iter: iterative SPN encrypt/decrypt core, one round per clock over a shared round unit
module spn_cu_iter
  import spn_cu_iter_pkg::*;
#(
  parameter int BLOCK_W    = 16,
  parameter int KEY_W      = 32,
  parameter int NUM_ROUNDS = 3,
  parameter int KEY_ROT    = 8
) (
  input logic         clk,
  input logic         rst_n,
  spn_cu_iter_if.slave cu
);
  localparam int CW      = $clog2(NUM_ROUNDS + 1);
  localparam int FIN_ROT = (NUM_ROUNDS * KEY_ROT) % KEY_W;
  localparam logic [CW-1:0] LAST = CW'(NUM_ROUNDS - 1);

  function automatic logic [BLOCK_W-1:0] round_key(input logic [KEY_W-1:0] k, input int a);
    round_key = '0;
    for (int j = 0; j < BLOCK_W; j++) round_key[j] = k[(j + KEY_W - a) % KEY_W];
  endfunction

  spn_state_e         state_q, state_d;
  spn_op_e            op, mode_q, mode_d, omode_q, omode_d;
  logic [BLOCK_W-1:0] x_q, x_d, dout_q, dout_d, rk, kr, y;
  logic [KEY_W-1:0]   key_q, key_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               err_q, err_d, go, run, last;

  always_comb begin
    op   = spn_op_e'(cu.opcode);
    go   = state_q == IDLE && cu.in_valid && op_legal(op);
    run  = state_q == RUN;
    last = mode_q == OP_ENC ? cnt_q == LAST : cnt_q == '0;
    rk   = round_key(key_q, (int'(cnt_q) * KEY_ROT) % KEY_W);
    // the whitening key comes from the live port on accept, from the latched key afterwards
    kr   = state_q == IDLE ? round_key(cu.symmetric_secret_key, FIN_ROT) : round_key(key_q, FIN_ROT);
  end

  spn_round_unit #(.BLOCK_W(BLOCK_W)) u_round (
    .x_i        (x_q),
    .round_key_i(rk),
    .mode_i     (mode_q),
    .y_o        (y)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q == IDLE ? (go ? RUN : IDLE)
            : state_q == RUN  ? (last ? DONE : RUN)
            : (cu.out_ready ? IDLE : DONE);
  end

  always_comb begin
    cu.in_ready   = state_q == IDLE;
    cu.out_valid  = state_q == DONE;
    cu.busy       = state_q != IDLE;
    cu.data_out   = dout_q;
    cu.out_mode   = omode_q;
    cu.err_opcode = err_q;
  end

  always_comb begin
    x_d     = go ? (op == OP_DEC ? cu.data_in ^ kr : cu.data_in) : run ? y : x_q;
    key_d   = go ? cu.symmetric_secret_key : key_q;
    mode_d  = go ? op : mode_q;
    cnt_d   = go ? (op == OP_ENC ? '0 : LAST)
            : run && !last ? (mode_q == OP_ENC ? cnt_q + 1'b1 : cnt_q - 1'b1)
            : cnt_q;
    dout_d  = run && last ? (mode_q == OP_ENC ? y ^ kr : y) : dout_q;
    omode_d = run && last ? mode_q : omode_q;
    err_d   = state_q == IDLE && cu.in_valid && !op_legal(op);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q     <= '0;
      key_q   <= '0;
      mode_q  <= OP_NOP;
      cnt_q   <= '0;
      dout_q  <= '0;
      omode_q <= OP_NOP;
      err_q   <= 1'b0;
    end else begin
      x_q     <= x_d;
      key_q   <= key_d;
      mode_q  <= mode_d;
      cnt_q   <= cnt_d;
      dout_q  <= dout_d;
      omode_q <= omode_d;
      err_q   <= err_d;
    end
  end
endmodule

// File: tb/tb_spn_cu_iter.sv
// tb_spn_cu_iter: randomized self-checking bench for spn_cu_iter against a spec-level model
module tb_spn_cu_iter;
  logic clk, rst_n;
  int n_tests = 0, n_fail = 0;
  logic [3:0] sb [16] = '{4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
                          4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2};
  logic [3:0] sbi [16];

  spn_cu_iter_if #(.BLOCK_W(16), .KEY_W(32)) if16 ();
  spn_cu_iter_if #(.BLOCK_W(32), .KEY_W(64)) if32 ();

  spn_cu_iter #(.BLOCK_W(16), .KEY_W(32), .NUM_ROUNDS(3), .KEY_ROT(8)) dut16 (
    .clk(clk), .rst_n(rst_n), .cu(if16));
  spn_cu_iter #(.BLOCK_W(32), .KEY_W(64), .NUM_ROUNDS(7), .KEY_ROT(12)) dut32 (
    .clk(clk), .rst_n(rst_n), .cu(if32));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] rkey(input logic [63:0] k, input int kw, input int bw, input int i, input int rot);
    logic [63:0] r = '0;
    int a = (i * rot) % kw;
    for (int j = 0; j < kw; j++) r[(j + a) % kw] = k[j];
    return r & ((64'd1 << bw) - 64'd1);
  endfunction

  function automatic int pdst(input int p, input int bw);
    return p == bw - 1 ? p : (p * (bw / 4)) % (bw - 1);
  endfunction

  function automatic logic [63:0] perm(input logic [63:0] x, input int bw, input bit inv);
    logic [63:0] y = '0;
    for (int p = 0; p < bw; p++) begin
      if (inv) y[p] = x[pdst(p, bw)];
      else     y[pdst(p, bw)] = x[p];
    end
    return y;
  endfunction

  function automatic logic [63:0] sub(input logic [63:0] x, input int bw, input bit inv);
    logic [63:0] y = '0;
    for (int n = 0; n < bw / 4; n++) y[4*n +: 4] = inv ? sbi[x[4*n +: 4]] : sb[x[4*n +: 4]];
    return y;
  endfunction

  function automatic logic [63:0] enc_m(input logic [63:0] d, k, input int bw, kw, r, rot);
    logic [63:0] x = d;
    for (int i = 0; i < r; i++) x = perm(sub(x ^ rkey(k, kw, bw, i, rot), bw, 0), bw, 0);
    return x ^ rkey(k, kw, bw, r, rot);
  endfunction

  function automatic logic [63:0] dec_m(input logic [63:0] d, k, input int bw, kw, r, rot);
    logic [63:0] x = d ^ rkey(k, kw, bw, r, rot);
    for (int i = r - 1; i >= 0; i--) x = sub(perm(x, bw, 1), bw, 1) ^ rkey(k, kw, bw, i, rot);
    return x;
  endfunction

  function automatic logic ov(input bit w);  return w ? if32.out_valid : if16.out_valid;  endfunction
  function automatic logic ir(input bit w);  return w ? if32.in_ready : if16.in_ready;    endfunction
  function automatic logic bs(input bit w);  return w ? if32.busy : if16.busy;            endfunction
  function automatic logic [1:0] om(input bit w); return w ? if32.out_mode : if16.out_mode; endfunction
  function automatic logic [63:0] rd(input bit w);
    return w ? 64'(if32.data_out) : 64'(if16.data_out);
  endfunction

  task automatic drive(input bit w, input logic v, input logic [1:0] opc, input logic [63:0] d, k);
    if (w) begin
      if32.in_valid = v; if32.opcode = opc; if32.data_in = d[31:0]; if32.symmetric_secret_key = k;
    end else begin
      if16.in_valid = v; if16.opcode = opc; if16.data_in = d[15:0]; if16.symmetric_secret_key = k[31:0];
    end
  endtask

  task automatic set_ordy(input bit w, input logic v);
    if (w) if32.out_ready = v;
    else   if16.out_ready = v;
  endtask

  task automatic run_op(input bit w, input logic [1:0] opc, input logic [63:0] din, key,
                        input int hold, output logic [63:0] res);
    int bw, kw, r, rot, lat;
    logic [63:0] exp;
    bw = w ? 32 : 16; kw = w ? 64 : 32; r = w ? 7 : 3; rot = w ? 12 : 8;
    exp = opc == 2'b01 ? enc_m(din, key, bw, kw, r, rot) : dec_m(din, key, bw, kw, r, rot);
    @(negedge clk);
    check("ready_idle", ir(w), 1);
    drive(w, 1, opc, din, key);
    @(negedge clk);
    drive(w, 0, 2'($urandom), {$urandom, $urandom}, key);
    lat = 0;
    while (!ov(w) && lat < 40) begin
      if (lat == 0) begin
        check("ready_run", ir(w), 0);
        check("busy_run", bs(w), 1);
      end
      @(negedge clk);
      lat++;
      if (lat == 1) drive(w, 0, 2'($urandom), {$urandom, $urandom}, 64'd0);
    end
    check("latency", lat, r);
    check("data_out", rd(w), exp);
    check("out_mode", om(w), opc);
    res = rd(w);
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      check("hold_valid", ov(w), 1);
      check("hold_data", rd(w), exp);
      check("hold_mode", om(w), opc);
    end
    set_ordy(w, 1);
    @(negedge clk);
    set_ordy(w, 0);
    check("valid_drop", ov(w), 0);
    check("ready_back", ir(w), 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] c, p, d, k, exp;
    int lat;
    bit seen;
    for (int i = 0; i < 16; i++) sbi[sb[i]] = 4'(i);
    rst_n = 1'b0;
    drive(0, 0, 2'b00, 64'd0, 64'd0);
    drive(1, 0, 2'b00, 64'd0, 64'd0);
    set_ordy(0, 0);
    set_ordy(1, 0);
    #2;
    check("rst_ready", ir(0), 1);
    check("rst_valid", ov(0), 0);
    check("rst_data", rd(0), 0);
    check("rst_mode", om(0), 0);
    check("rst_busy", bs(0), 0);
    check("rst_err", if16.err_opcode, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // round trip with backpressure on the ciphertext
    run_op(0, 2'b01, 64'h1234, 64'hA5A5_5A5A, 6, c);
    check("ct_differs", c == 64'h1234, 0);
    run_op(0, 2'b10, c, 64'hA5A5_5A5A, 0, p);
    check("round_trip", p, 64'h1234);

    for (int i = 0; i < 10; i++) begin
      d = 64'($urandom_range(0, 16'hFFFF));
      k = 64'($urandom);
      run_op(0, 2'b01, d, k, $urandom_range(0, 2), c);
      run_op(0, 2'b10, c, k, 0, p);
      check("rand_trip", p, d);
      run_op(0, 2'b10, 64'($urandom_range(0, 16'hFFFF)), k, $urandom_range(0, 1), p);
    end
    run_op(0, 2'b01, 64'h0000, 64'h0, 0, c);
    run_op(0, 2'b10, 64'hFFFF, 64'hFFFF_FFFF, 0, p);

    // illegal opcodes are consumed with a single error pulse
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      drive(0, 1, i == 0 ? 2'b11 : 2'b00, 64'h5555, 64'h1);
      @(negedge clk);
      drive(0, 0, 2'b01, 64'h0, 64'h0);
      check("err_pulse", if16.err_opcode, 1);
      check("err_novalid", ov(0), 0);
      check("err_idle", bs(0), 0);
      @(negedge clk);
      check("err_clear", if16.err_opcode, 0);
      check("err_novalid2", ov(0), 0);
    end

    // in_valid held high through an operation is taken again only after returning to IDLE
    d = 64'h0BEE; k = 64'h1357_9BDF;
    exp = enc_m(d, k, 16, 32, 3, 8);
    @(negedge clk);
    drive(0, 1, 2'b01, d, k);
    @(negedge clk);
    seen = 0; lat = 0;
    while (!ov(0) && lat < 40) begin
      seen |= ir(0);
      @(negedge clk);
      lat++;
    end
    check("held_noready", seen, 0);
    check("held_data", rd(0), exp);
    set_ordy(0, 1);
    @(negedge clk);
    set_ordy(0, 0);
    check("held_ready", ir(0), 1);
    @(negedge clk);
    drive(0, 0, 2'b01, d, k);
    check("held_reaccept", bs(0), 1);
    lat = 0;
    while (!ov(0) && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check("held_data2", rd(0), exp);
    set_ordy(0, 1);
    @(negedge clk);
    set_ordy(0, 0);

    // reset mid-RUN aborts with no result
    @(negedge clk);
    drive(0, 1, 2'b01, 64'h4321, 64'hDEAD_0001);
    @(negedge clk);
    drive(0, 0, 2'b01, 64'h0, 64'h0);
    @(negedge clk);
    check("pre_rst_busy", bs(0), 1);
    rst_n = 1'b0;
    #1;
    check("arst_valid", ov(0), 0);
    check("arst_data", rd(0), 0);
    check("arst_busy", bs(0), 0);
    check("arst_ready", ir(0), 1);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rel_ready", ir(0), 1);
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      seen |= ov(0);
    end
    check("rel_noresult", seen, 0);

    // wide configuration
    k = {$urandom, $urandom};
    run_op(1, 2'b01, 64'hDEAD_BEEF, k, 2, c);
    run_op(1, 2'b10, c, k, 0, p);
    check("wide_trip", p, 64'hDEAD_BEEF);
    for (int i = 0; i < 3; i++) begin
      d = 64'($urandom);
      k = {$urandom, $urandom};
      run_op(1, 2'b01, d, k, 0, c);
      run_op(1, 2'b10, c, k, 0, p);
      check("wide_rand_trip", p, d);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
